// File: rtl/lockstep_alu_n.sv
// Dual-lane lockstep ALU: two 2-stage ALU lanes whose results are compared beat by beat,
// with a saturating mismatch counter. Define LOCKSTEP_FAULT_INJ_EN to add the inject_i port.
module lockstep_alu_n #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [1:0]       sel1,
    input  logic [1:0]       sel2,
`ifdef LOCKSTEP_FAULT_INJ_EN
    input  logic             inject_i,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out1,
    output logic [WIDTH-1:0] alu_out2,
    output logic             carry1,
    output logic             carry2,
    output logic [WIDTH-1:0] diff,
    output logic             carry_diff,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [CNT_W-1:0] mismatch_cnt,
    input  logic             clear_i
);

    localparam logic [1:0]       OP_ADD  = 2'b00;
    localparam logic [1:0]       OP_SUB  = 2'b01;
    localparam logic [1:0]       OP_AND  = 2'b10;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Returns {carry, result}; for SUB the carry is the borrow (a < b).
    function automatic logic [WIDTH:0] alu_op(input logic [1:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        logic [WIDTH:0] r;
        case (op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {(a < b), a - b};
            OP_AND:  r = {1'b0, a & b};
            default: r = {1'b0, a ^ b};
        endcase
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    logic             vld_p1;
    logic [WIDTH-1:0] a0_p1, b0_p1, a1_p1, b1_p1;
    logic [1:0]       sel1_p1, sel2_p1;

    logic             vld_p2;
    logic [WIDTH-1:0] out1_p2, out2_p2, diff_p2;
    logic             c1_p2, c2_p2, cdiff_p2;

    logic [WIDTH:0]   res1, res2;
    logic             s2_load;
    logic             cnt_hit;
    logic [CNT_W-1:0] cnt_q;
    logic             sticky_q;

    assign s2_load  = !vld_p2 || out_ready;
    assign in_ready = wb_rst_n && (!vld_p1 || s2_load);

    // ---- stage 1: operand/opcode capture ----
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            vld_p1 <= 1'b0;
        end else if (in_ready) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (in_ready && in_valid) begin
            a0_p1   <= a0;
            b0_p1   <= b0;
            a1_p1   <= a1;
            b1_p1   <= b1;
            sel1_p1 <= sel1;
            sel2_p1 <= sel2;
        end
    end

    assign res1 = alu_op(sel1_p1, a0_p1, b0_p1);
`ifdef LOCKSTEP_FAULT_INJ_EN
    assign res2 = alu_op(sel2_p1, a1_p1, b1_p1) ^ {{WIDTH{1'b0}}, inject_i};
`else
    assign res2 = alu_op(sel2_p1, a1_p1, b1_p1);
`endif

    // ---- stage 2: results and lane comparison ----
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            vld_p2   <= 1'b0;
            out1_p2  <= '0;
            out2_p2  <= '0;
            c1_p2    <= 1'b0;
            c2_p2    <= 1'b0;
            diff_p2  <= '0;
            cdiff_p2 <= 1'b0;
        end else if (s2_load) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                out1_p2  <= res1[WIDTH-1:0];
                out2_p2  <= res2[WIDTH-1:0];
                c1_p2    <= res1[WIDTH];
                c2_p2    <= res2[WIDTH];
                diff_p2  <= res1[WIDTH-1:0] ^ res2[WIDTH-1:0];
                cdiff_p2 <= res1[WIDTH] ^ res2[WIDTH];
            end
        end
    end

    assign mismatch = vld_p2 && ((diff_p2 != '0) || cdiff_p2);
    assign cnt_hit  = mismatch && out_ready;

    // A clear that lands on a counted beat restarts the count at that beat.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else if (clear_i) begin
            cnt_q    <= CNT_W'(cnt_hit);
            sticky_q <= cnt_hit;
        end else if (cnt_hit) begin
            cnt_q    <= sat_inc(cnt_q);
            sticky_q <= 1'b1;
        end
    end

    assign out_valid    = vld_p2;
    assign alu_out1     = out1_p2;
    assign alu_out2     = out2_p2;
    assign carry1       = c1_p2;
    assign carry2       = c2_p2;
    assign diff         = diff_p2;
    assign carry_diff   = cdiff_p2;
    assign err_sticky   = sticky_q;
    assign mismatch_cnt = cnt_q;

endmodule

// File: tb/tb_lockstep_alu_n.sv
// Bench for lockstep_alu_n: two instances (CNT_W=8 and CNT_W=2) share stimulus and are
// checked every cycle against a queue-based model of in-flight beats.
module tb_lockstep_alu_n;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic clk = 1'b0;
    logic wb_rst_n = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b0, clear_i = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0] sel1 = '0, sel2 = '0;
`ifdef LOCKSTEP_FAULT_INJ_EN
    logic inject_i = 1'b0;
`endif

    logic in_ready, out_valid, carry1, carry2, carry_diff, mismatch, err_sticky;
    logic [W-1:0] alu_out1, alu_out2, diff;
    logic [7:0] mismatch_cnt;
    logic in_ready_b, out_valid_b, carry1_b, carry2_b, carry_diff_b, mismatch_b, err_sticky_b;
    logic [W-1:0] alu_out1_b, alu_out2_b, diff_b;
    logic [1:0] mismatch_cnt_b;

    always #5 clk = ~clk;

    lockstep_alu_n #(.WIDTH(W), .CNT_W(8)) dut (
        .wb_clk_i(clk), .wb_rst_n(wb_rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .sel1(sel1), .sel2(sel2),
`ifdef LOCKSTEP_FAULT_INJ_EN
        .inject_i(inject_i),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .alu_out1(alu_out1), .alu_out2(alu_out2),
        .carry1(carry1), .carry2(carry2), .diff(diff), .carry_diff(carry_diff),
        .mismatch(mismatch), .err_sticky(err_sticky), .mismatch_cnt(mismatch_cnt), .clear_i(clear_i));

    lockstep_alu_n #(.WIDTH(W), .CNT_W(2)) dut_b (
        .wb_clk_i(clk), .wb_rst_n(wb_rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .sel1(sel1), .sel2(sel2),
`ifdef LOCKSTEP_FAULT_INJ_EN
        .inject_i(inject_i),
`endif
        .out_valid(out_valid_b), .out_ready(out_ready), .alu_out1(alu_out1_b), .alu_out2(alu_out2_b),
        .carry1(carry1_b), .carry2(carry2_b), .diff(diff_b), .carry_diff(carry_diff_b),
        .mismatch(mismatch_b), .err_sticky(err_sticky_b), .mismatch_cnt(mismatch_cnt_b), .clear_i(clear_i));

    typedef struct { int o1; int c1; int o2; int c2; int age; bit mis; } beat_t;
    beat_t q[$];
    int cnt_a = 0, cnt_b = 0;
    bit stk = 0;
    int n_tests = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ref_alu(input int sel, input int a, input int b, output int c);
        int s;
        c = 0;
        case (sel)
            0: begin s = a + b; c = (s >= M) ? 1 : 0; return s % M; end
            1: begin c = (a < b) ? 1 : 0; return (a - b + M) % M; end
            2: return a & b;
            default: return a ^ b;
        endcase
    endfunction

    // Called at a falling edge with inputs already applied; advances one clock.
    task automatic tick();
        bit rdy, ov, pop, counted;
        beat_t e;
        logic [15:0] ev;
        #1;
        rdy = (q.size() < 2) || out_ready;
        chk("in_ready", in_ready, rdy);
        chk("in_ready_b", in_ready_b, rdy);
        ov = (q.size() > 0) && (q[0].age >= 1);
        pop = ov && out_ready;
        counted = pop && q[0].mis;
        if (pop) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (in_valid && rdy) begin
            e.o1 = ref_alu(sel1, a0, b0, e.c1);
            e.o2 = ref_alu(sel2, a1, b1, e.c2);
`ifdef LOCKSTEP_FAULT_INJ_EN
            if (inject_i) e.o2 = e.o2 ^ 1;
`endif
            e.mis = (e.o1 != e.o2) || (e.c1 != e.c2);
            e.age = 0;
            q.push_back(e);
        end
        if (clear_i) begin
            cnt_a = counted; cnt_b = counted; stk = counted;
        end else if (counted) begin
            if (cnt_a < 255) cnt_a++;
            if (cnt_b < 3) cnt_b++;
            stk = 1;
        end
        @(negedge clk);
        ov = (q.size() > 0) && (q[0].age >= 1);
        chk("out_valid", out_valid, ov);
        chk("out_valid_b", out_valid_b, ov);
        if (ov) begin
            ev = {q[0].o1[W-1:0], q[0].o2[W-1:0], q[0].c1[0], q[0].c2[0],
                  q[0].o1[W-1:0] ^ q[0].o2[W-1:0], q[0].c1[0] ^ q[0].c2[0], q[0].mis};
            chk("lanes", {alu_out1, alu_out2, carry1, carry2, diff, carry_diff, mismatch}, ev);
            chk("lanes_b", {alu_out1_b, alu_out2_b, carry1_b, carry2_b, diff_b, carry_diff_b, mismatch_b}, ev);
        end else begin
            chk("mismatch_idle", {mismatch, mismatch_b}, 0);
        end
        chk("mismatch_cnt", mismatch_cnt, cnt_a);
        chk("mismatch_cnt_b", mismatch_cnt_b, cnt_b);
        chk("err_sticky", {err_sticky, err_sticky_b}, {stk, stk});
    endtask

    task automatic beat(input logic [1:0] s1, input logic [1:0] s2, input int x0, input int y0,
                        input int x1, input int y1);
        in_valid = 1'b1; sel1 = s1; sel2 = s2;
        a0 = W'(x0); b0 = W'(y0); a1 = W'(x1); b1 = W'(y1);
    endtask

    task automatic do_reset();
        wb_rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {out_valid, out_valid_b}, 0);
        chk("rst_in_ready", {in_ready, in_ready_b}, 0);
        chk("rst_cnt", {mismatch_cnt, mismatch_cnt_b}, 0);
        chk("rst_flags", {mismatch, err_sticky, carry1, carry2, carry_diff}, 0);
        chk("rst_data", {alu_out1, alu_out2, diff}, 0);
        q.delete(); cnt_a = 0; cnt_b = 0; stk = 0;
        @(negedge clk);
        @(negedge clk);
        wb_rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; out_ready = 1'b1; clear_i = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        int c, r;
        // Model pinned against hand-computed values
        r = ref_alu(0, 9, 8, c);   chk("model_add", {c[0], r[3:0]}, 5'h11);
        r = ref_alu(1, 3, 5, c);   chk("model_sub", {c[0], r[3:0]}, 5'h1E);
        r = ref_alu(2, 15, 5, c);  chk("model_and", {c[0], r[3:0]}, 5'h05);
        r = ref_alu(3, 10, 6, c);  chk("model_xor", {c[0], r[3:0]}, 5'h0C);

        #2;
        chk("reset_state", {in_ready, out_valid, mismatch, err_sticky, mismatch_cnt}, 0);
        @(negedge clk);
        wb_rst_n = 1'b1;

        // ADD 9+8 on both lanes
        beat(2'b00, 2'b00, 9, 8, 9, 8); out_ready = 1'b0; tick();
        in_valid = 1'b0; tick();
        chk("add_out", {alu_out1, alu_out2, carry1, carry2, mismatch}, {4'h1, 4'h1, 1'b1, 1'b1, 1'b0});
        idle(2);

        // ADD vs SUB on 5,3
        beat(2'b00, 2'b01, 5, 3, 5, 3); out_ready = 1'b1; tick();
        in_valid = 1'b0; out_ready = 1'b0; tick();
        chk("addsub_out", {alu_out1, alu_out2, diff, mismatch}, {4'h8, 4'h2, 4'hA, 1'b1});
        out_ready = 1'b1; tick();
        chk("addsub_cnt", {mismatch_cnt, err_sticky}, {8'd1, 1'b1});
        idle(2);

        // SUB 3-5 then a 3-cycle output stall with input pressure
        beat(2'b01, 2'b01, 3, 5, 3, 5); out_ready = 1'b0; tick();
        beat(2'b00, 2'b00, 1, 2, 1, 2); tick();
        chk("sub_out", {alu_out1, carry1, alu_out2, carry2, mismatch}, {4'hE, 1'b1, 4'hE, 1'b1, 1'b0});
        beat(2'b11, 2'b11, 6, 3, 6, 3);
        repeat (2) begin
            tick();
            chk("stall_hold", {out_valid, alu_out1, carry1}, {1'b1, 4'hE, 1'b1});
            chk("stall_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1; tick();
        idle(4);
        chk("stall_drained", q.size(), 0);

        // Counter saturation on the CNT_W=2 instance, then clear on a counted beat
        clear_i = 1'b1; in_valid = 1'b0; tick(); clear_i = 1'b0;
        out_ready = 1'b1;
        repeat (5) begin beat(2'b00, 2'b10, 5, 3, 5, 3); tick(); end
        idle(3);
        chk("sat_cnt", {mismatch_cnt, mismatch_cnt_b}, {8'd5, 2'd3});
        beat(2'b00, 2'b10, 5, 3, 5, 3); tick();
        in_valid = 1'b0; tick();
        clear_i = 1'b1; tick(); clear_i = 1'b0;
        chk("clear_hit", {mismatch_cnt, mismatch_cnt_b, err_sticky, err_sticky_b}, {8'd1, 2'd1, 1'b1, 1'b1});
        idle(2);

`ifdef LOCKSTEP_FAULT_INJ_EN
        inject_i = 1'b1;
        beat(2'b10, 2'b10, 15, 5, 15, 5); out_ready = 1'b0; tick();
        in_valid = 1'b0; tick();
        chk("inject_out", {alu_out2, diff, mismatch}, {4'h4, 4'h1, 1'b1});
        inject_i = 1'b0;
        idle(2);
`endif

        // Reset with two beats in flight
        out_ready = 1'b0;
        beat(2'b00, 2'b01, 7, 2, 7, 2); tick();
        beat(2'b11, 2'b11, 4, 4, 4, 4); tick();
        do_reset();
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            tick();
            chk("post_rst_quiet", {out_valid, mismatch_cnt}, 0);
        end

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 70);
            clear_i   = ($urandom_range(0, 99) < 4);
            sel1 = 2'($urandom); sel2 = ($urandom_range(0, 1) == 0) ? sel1 : 2'($urandom);
            a0 = W'($urandom); b0 = W'($urandom);
            a1 = ($urandom_range(0, 1) == 0) ? a0 : W'($urandom);
            b1 = ($urandom_range(0, 1) == 0) ? b0 : W'($urandom);
            if ($urandom_range(0, 299) == 0) do_reset();
            else tick();
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
